// File: rtl/exc_commit_arbiter_pkg.sv
// Shared cause codes, exception-vector bit indices and FSM states for the commit arbiter.
// Optional TLB causes are enabled by defining EXC_TLB_EN.
package exc_commit_arbiter_pkg;

  localparam int EXCT_W = 4;
  typedef logic [EXCT_W-1:0] exct_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_WAIT  = 2'd2
  } exc_state_e;

  localparam exct_t EXC_NONE   = 4'd0;
  localparam exct_t EXC_INTR   = 4'd1;
  localparam exct_t EXC_ADEL1  = 4'd2;
  localparam exct_t EXC_ADEL2  = 4'd3;
  localparam exct_t EXC_ADES   = 4'd4;
  localparam exct_t EXC_OV     = 4'd5;
  localparam exct_t EXC_SYSC   = 4'd6;
  localparam exct_t EXC_BP     = 4'd7;
  localparam exct_t EXC_RI     = 4'd8;
  localparam exct_t EXC_ERET   = 4'd9;
  localparam exct_t EXC_TLBL_R = 4'd10;
  localparam exct_t EXC_TLBL   = 4'd11;
  localparam exct_t EXC_TLBL_D = 4'd12;
  localparam exct_t EXC_TLBS   = 4'd13;
  localparam exct_t EXC_MOD    = 4'd14;

  // Bit positions inside a lane's exception vector
  localparam int EXCB_INTR   = 0;
  localparam int EXCB_ADEL1  = 1;
  localparam int EXCB_ADEL2  = 2;
  localparam int EXCB_ADES   = 3;
  localparam int EXCB_OV     = 4;
  localparam int EXCB_SYSC   = 5;
  localparam int EXCB_BP     = 6;
  localparam int EXCB_RI     = 7;
  localparam int EXCB_ERET   = 8;
  localparam int EXCB_TLBL_R = 9;
  localparam int EXCB_TLBL   = 10;
  localparam int EXCB_TLBL_D = 11;
  localparam int EXCB_TLBS   = 12;
  localparam int EXCB_MOD    = 13;

`ifdef EXC_TLB_EN
  localparam int EXCV_W_DEF = 14;
`else
  localparam int EXCV_W_DEF = 9;
`endif

  // A delay-slot instruction restarts at its branch, one word earlier (wraps mod 2^32)
  function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic bd);
    return bd ? (pc - 32'd4) : pc;
  endfunction

endpackage

// File: rtl/exc_commit_arbiter_lane_prio.sv
// Per-lane exception priority encoder: vector -> cause code and BadVAddr source select.
// TLB causes are included when EXC_TLB_EN is defined.
module exc_lane_prio
  import exc_commit_arbiter_pkg::*;
#(
  parameter int EXCV_W = EXCV_W_DEF
) (
  input  logic [EXCV_W-1:0] excs_i,
  input  logic              intr_i,
  output exct_t             code_o,
  output logic              baddr_pc_o,
  output logic              baddr_mem_o
);

  // The vector's own Intr bit is ignored; the interrupt is attached by the arbiter
  logic unused_intr_bit;
  assign unused_intr_bit = excs_i[EXCB_INTR];

  always_comb begin
    code_o      = EXC_NONE;
    baddr_pc_o  = 1'b0;
    baddr_mem_o = 1'b0;
    if (intr_i) begin
      code_o = EXC_INTR;
    end else if (excs_i[EXCB_ADEL1]) begin
      code_o     = EXC_ADEL1;
      baddr_pc_o = 1'b1;
`ifdef EXC_TLB_EN
    end else if (excs_i[EXCB_TLBL_R]) begin
      code_o     = EXC_TLBL_R;
      baddr_pc_o = 1'b1;
    end else if (excs_i[EXCB_TLBL]) begin
      code_o     = EXC_TLBL;
      baddr_pc_o = 1'b1;
`endif
    end else if (excs_i[EXCB_ADEL2]) begin
      code_o      = EXC_ADEL2;
      baddr_mem_o = 1'b1;
    end else if (excs_i[EXCB_ADES]) begin
      code_o      = EXC_ADES;
      baddr_mem_o = 1'b1;
`ifdef EXC_TLB_EN
    end else if (excs_i[EXCB_TLBL_D]) begin
      code_o      = EXC_TLBL_D;
      baddr_mem_o = 1'b1;
    end else if (excs_i[EXCB_TLBS]) begin
      code_o      = EXC_TLBS;
      baddr_mem_o = 1'b1;
    end else if (excs_i[EXCB_MOD]) begin
      code_o      = EXC_MOD;
      baddr_mem_o = 1'b1;
`endif
    end else if (excs_i[EXCB_OV]) begin
      code_o = EXC_OV;
    end else if (excs_i[EXCB_SYSC]) begin
      code_o = EXC_SYSC;
    end else if (excs_i[EXCB_BP]) begin
      code_o = EXC_BP;
    end else if (excs_i[EXCB_RI]) begin
      code_o = EXC_RI;
    end else if (excs_i[EXCB_ERET]) begin
      code_o = EXC_ERET;
    end
  end

endmodule

// File: rtl/exc_commit_arbiter.sv
// Commit-boundary exception resolver: oldest faulting lane wins, younger lanes are killed,
// CP0 fields are registered and a held flush/redirect runs until fetch acks. TLB causes: EXC_TLB_EN.
module exc_commit_arbiter
  import exc_commit_arbiter_pkg::*;
#(
  parameter int          LANES      = 2,
  parameter int          EXCV_W     = EXCV_W_DEF,
  parameter logic [31:0] EXC_VEC    = 32'hBFC0_0380,
  parameter logic [31:0] REFILL_VEC = 32'hBFC0_0200
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [LANES*32-1:0]       exc_pc_i,
  input  logic [LANES-1:0]          exc_pcvalid_i,
  input  logic [LANES-1:0]          exc_bd_i,
  input  logic [LANES-1:0]          exc_mem_en_i,
  input  logic [LANES*32-1:0]       exc_m_addr_i,
  input  logic [LANES*EXCV_W-1:0]   exc_excs_i,
  input  logic [31:0]               exc_EPC_i,
  input  logic                      exc_intr_i,
  input  logic                      exc_exl_i,
  input  logic                      fetch_ack_i,
  output logic [LANES-1:0]          exc_kill_o,
  output logic                      exc_flag_o,
  output logic [EXCT_W-1:0]         exc_type_o,
  output logic [31:0]               exc_baddr_o,
  output logic [31:0]               exc_epc_o,
  output logic                      exc_bd_o,
  output logic                      flush_o,
  output logic [31:0]               flush_pc_o,
  output logic                      exc_busy_o
);

  exc_state_e state_q, state_d;
  logic       intr_pend_q;

  logic [LANES-1:0] intr_lane;
  logic             intr_seen;
  exct_t            lane_code [LANES];
  logic [LANES-1:0] lane_bsel_pc, lane_bsel_mem;

  logic             win_found;
  logic [LANES-1:0] win_kill;
  exct_t            win_code;
  logic [31:0]      win_pc, win_maddr;
  logic             win_bd, win_sel_pc, win_sel_mem;

  logic             take;
  logic [31:0]      baddr_d, epc_d, fpc_d;

  logic             flag_q, bd_q;
  exct_t            type_q;
  logic [31:0]      baddr_q, epc_q, fpc_q;

  // Interrupt rides on the oldest real instruction that has no memory access in flight
  always_comb begin
    intr_lane = '0;
    intr_seen = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (!intr_seen && exc_pcvalid_i[i] && !exc_mem_en_i[i]) begin
        intr_lane[i] = intr_pend_q;
        intr_seen    = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    exc_lane_prio #(.EXCV_W(EXCV_W)) u_prio (
      .excs_i      (exc_excs_i[g*EXCV_W +: EXCV_W]),
      .intr_i      (intr_lane[g]),
      .code_o      (lane_code[g]),
      .baddr_pc_o  (lane_bsel_pc[g]),
      .baddr_mem_o (lane_bsel_mem[g])
    );
  end

  always_comb begin
    win_found   = 1'b0;
    win_kill    = '0;
    win_code    = EXC_NONE;
    win_pc      = '0;
    win_maddr   = '0;
    win_bd      = 1'b0;
    win_sel_pc  = 1'b0;
    win_sel_mem = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (!win_found && exc_pcvalid_i[i] && (lane_code[i] != EXC_NONE)) begin
        win_found   = 1'b1;
        win_code    = lane_code[i];
        win_pc      = exc_pc_i[i*32 +: 32];
        win_maddr   = exc_m_addr_i[i*32 +: 32];
        win_bd      = exc_bd_i[i];
        win_sel_pc  = lane_bsel_pc[i];
        win_sel_mem = lane_bsel_mem[i];
      end
      win_kill[i] = win_found;
    end
  end

  assign take       = (state_q == ST_IDLE) && win_found;
  assign exc_kill_o = (state_q == ST_IDLE) ? win_kill : '1;

  always_comb begin
    baddr_d = win_sel_pc ? win_pc : (win_sel_mem ? win_maddr : 32'd0);
    epc_d   = (win_code == EXC_ERET) ? 32'd0 : epc_of(win_pc, win_bd);
    fpc_d   = EXC_VEC;
    if (win_code == EXC_ERET) begin
      fpc_d = exc_EPC_i;
    end
`ifdef EXC_TLB_EN
    else if ((win_code == EXC_TLBL_R) && !exc_exl_i) begin
      fpc_d = REFILL_VEC;
    end
`endif
  end

`ifndef EXC_TLB_EN
  logic unused_exl;
  logic [31:0] unused_refill;
  assign unused_exl    = exc_exl_i;
  assign unused_refill = REFILL_VEC;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (win_found) state_d = ST_FLUSH;
      ST_FLUSH: state_d = fetch_ack_i ? ST_IDLE : ST_WAIT;
      ST_WAIT:  if (fetch_ack_i) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      intr_pend_q <= 1'b0;
      flag_q      <= 1'b0;
      type_q      <= EXC_NONE;
      baddr_q     <= '0;
      epc_q       <= '0;
      bd_q        <= 1'b0;
      fpc_q       <= '0;
    end else begin
      state_q     <= state_d;
      intr_pend_q <= exc_intr_i;
      flag_q      <= take;
      if (take) begin
        type_q  <= win_code;
        baddr_q <= baddr_d;
        epc_q   <= epc_d;
        bd_q    <= win_bd;
        fpc_q   <= fpc_d;
      end
    end
  end

  assign exc_flag_o  = flag_q;
  assign exc_type_o  = type_q;
  assign exc_baddr_o = baddr_q;
  assign exc_epc_o   = epc_q;
  assign exc_bd_o    = bd_q;
  assign flush_pc_o  = fpc_q;
  assign flush_o     = (state_q != ST_IDLE);
  assign exc_busy_o  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_exc_commit_arbiter.sv
// Randomized bench for exc_commit_arbiter against a cause-table reference model.
module tb_exc_commit_arbiter;
  import exc_commit_arbiter_pkg::*;

  localparam int LANES  = 2;
  localparam int EXCV_W = EXCV_W_DEF;
`ifdef EXC_TLB_EN
  localparam int NPRIO = 13;
  localparam int PRIO [NPRIO] = '{2, 10, 11, 3, 4, 12, 13, 14, 5, 6, 7, 8, 9};
`else
  localparam int NPRIO = 8;
  localparam int PRIO [NPRIO] = '{2, 3, 4, 5, 6, 7, 8, 9};
`endif

  logic                    clk = 1'b0;
  logic                    rst;
  logic [LANES*32-1:0]     pc, maddr;
  logic [LANES-1:0]        pcv, bd, mem;
  logic [LANES*EXCV_W-1:0] excs;
  logic [31:0]             epc_in;
  logic                    intr, exl, ack;
  logic [LANES-1:0]        kill;
  logic                    flag, bd_o, flush, busy;
  logic [EXCT_W-1:0]       typ;
  logic [31:0]             baddr, epc, fpc;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: what has been committed to CP0 and whether a redirect is outstanding
  logic        m_pend, m_flush, m_flag, m_bd;
  int          m_type;
  logic [31:0] m_baddr, m_epc, m_fpc;

  exc_commit_arbiter #(.LANES(LANES), .EXCV_W(EXCV_W)) dut (
    .clk(clk), .rst(rst),
    .exc_pc_i(pc), .exc_pcvalid_i(pcv), .exc_bd_i(bd), .exc_mem_en_i(mem),
    .exc_m_addr_i(maddr), .exc_excs_i(excs), .exc_EPC_i(epc_in),
    .exc_intr_i(intr), .exc_exl_i(exl), .fetch_ack_i(ack),
    .exc_kill_o(kill), .exc_flag_o(flag), .exc_type_o(typ), .exc_baddr_o(baddr),
    .exc_epc_o(epc), .exc_bd_o(bd_o), .flush_o(flush), .flush_pc_o(fpc), .exc_busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = 0; m_flush = 0; m_flag = 0; m_bd = 0;
    m_type = 0; m_baddr = 0; m_epc = 0; m_fpc = 0;
  endtask

  task automatic clr_lanes();
    pc = '0; maddr = '0; pcv = '0; bd = '0; mem = '0; excs = '0;
    intr = 0; ack = 0; exl = 0; epc_in = 32'h0;
  endtask

  task automatic set_lane(input int i, input logic [31:0] lpc, input logic lbd, input logic lmem,
                          input int code, input logic [31:0] addr);
    logic [EXCV_W-1:0] v;
    v = '0;
    if (code > 1) v[code-1] = 1'b1;
    pcv[i] = 1'b1; bd[i] = lbd; mem[i] = lmem;
    pc[i*32 +: 32] = lpc; maddr[i*32 +: 32] = addr;
    excs[i*EXCV_W +: EXCV_W] = v;
  endtask

  // One commit cycle from the rules: pick cause per lane from the priority table, oldest lane wins
  task automatic model_eval(output logic [LANES-1:0] ekill, output logic hit, output int code,
                            output logic [31:0] ebaddr, output logic [31:0] eepc,
                            output logic [31:0] efpc, output logic ebd);
    int ilane;
    ilane = -1; hit = 0; ekill = '0; code = 0; ebaddr = 0; eepc = 0; efpc = 0; ebd = 0;
    if (m_pend)
      for (int i = 0; i < LANES; i++)
        if (ilane < 0 && pcv[i] && !mem[i]) ilane = i;
    for (int i = 0; i < LANES; i++) begin
      int c;
      logic [EXCV_W-1:0] v;
      logic [31:0] lpc;
      v = excs[i*EXCV_W +: EXCV_W];
      lpc = pc[i*32 +: 32];
      c = 0;
      if (i == ilane) c = 1;
      else
        for (int k = 0; k < NPRIO; k++)
          if (c == 0 && v[PRIO[k]-1]) c = PRIO[k];
      if (!hit && pcv[i] && c != 0) begin
        hit = 1; code = c; ebd = bd[i];
        if (c == 2 || c == 10 || c == 11) ebaddr = lpc;
        else if (c == 3 || c == 4 || c >= 12) ebaddr = maddr[i*32 +: 32];
        eepc = (c == 9) ? 32'd0 : (bd[i] ? lpc - 32'd4 : lpc);
        if (c == 9) efpc = epc_in;
        else if (c == 10 && !exl) efpc = 32'hBFC0_0200;
        else efpc = 32'hBFC0_0380;
      end
      if (hit) ekill[i] = 1'b1;
    end
    if (m_flush) begin
      ekill = '1; hit = 0;
    end
  endtask

  task automatic check_regs(input string tag);
    chk({tag, ".flag"}, flag, m_flag);
    chk({tag, ".flush"}, flush, m_flush);
    chk({tag, ".busy"}, busy, m_flush);
    chk({tag, ".type"}, typ, m_type);
    chk({tag, ".baddr"}, baddr, m_baddr);
    chk({tag, ".epc"}, epc, m_epc);
    chk({tag, ".bd"}, bd_o, m_bd);
    chk({tag, ".flush_pc"}, fpc, m_fpc);
  endtask

  // Entered just after a negedge with inputs already applied; returns at the next negedge
  task automatic run_cycle(input string tag);
    logic [LANES-1:0] ekill;
    logic hit, ebd;
    int code;
    logic [31:0] eb, ee, ef;
    #1;
    model_eval(ekill, hit, code, eb, ee, ef, ebd);
    chk({tag, ".kill"}, kill, ekill);
    @(posedge clk);
    #1;
    if (m_flush) begin
      if (ack) m_flush = 0;
    end else if (hit) begin
      m_flush = 1; m_type = code; m_baddr = eb; m_epc = ee; m_fpc = ef; m_bd = ebd;
    end
    m_flag = hit;
    m_pend = intr;
    check_regs(tag);
    @(negedge clk);
  endtask

  task automatic async_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    chk({tag, ".flush"}, flush, 0);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".type"}, typ, 0);
    chk({tag, ".flush_pc"}, fpc, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic randomize_inputs();
    clr_lanes();
    for (int i = 0; i < LANES; i++) begin
      logic [EXCV_W-1:0] v;
      v = '0;
      pcv[i] = ($urandom_range(0, 4) != 0);
      bd[i]  = $urandom_range(0, 1);
      mem[i] = $urandom_range(0, 1);
      pc[i*32 +: 32]    = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      maddr[i*32 +: 32] = $urandom;
      if ($urandom_range(0, 2) == 0) v[$urandom_range(0, EXCV_W-1)] = 1'b1;
      if ($urandom_range(0, 3) == 0) v[$urandom_range(0, EXCV_W-1)] = 1'b1;
      excs[i*EXCV_W +: EXCV_W] = v;
    end
    intr   = ($urandom_range(0, 4) == 0);
    ack    = ($urandom_range(0, 2) == 0);
    exl    = $urandom_range(0, 1);
    epc_in = $urandom;
  endtask

  initial begin
    rst = 1'b1;
    clr_lanes();
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_regs("reset");
    chk("reset.kill", kill, 0);
    @(negedge clk);

    // lane1 overflow, lane0 clean
    clr_lanes();
    set_lane(0, 32'h0000_1000, 0, 0, 0, 32'h0);
    set_lane(1, 32'h0000_1004, 0, 0, 5, 32'h0);
    run_cycle("ov");
    clr_lanes(); ack = 1; run_cycle("ov_ack");

    // lane0 AdEL2 beats lane1 SysC
    clr_lanes();
    set_lane(0, 32'h0000_2000, 0, 1, 3, 32'h0000_1003);
    set_lane(1, 32'h0000_2004, 0, 0, 6, 32'h0);
    run_cycle("adel2");
    clr_lanes(); ack = 1; run_cycle("adel2_ack");

    // interrupt skips lane0 with memory in flight, lands on delay-slot lane1
    clr_lanes(); intr = 1; run_cycle("intr_sync");
    clr_lanes(); intr = 1;
    set_lane(0, 32'h0000_00FC, 0, 1, 0, 32'h0);
    set_lane(1, 32'h0000_0100, 1, 0, 0, 32'h0);
    run_cycle("intr");
    clr_lanes(); ack = 1; run_cycle("intr_ack");

    // ERET with ack withheld; new causes during the hold are ignored
    clr_lanes(); epc_in = 32'hBFC0_1234;
    set_lane(0, 32'h0000_3000, 0, 0, 9, 32'h0);
    run_cycle("eret");
    for (int k = 0; k < 3; k++) begin
      clr_lanes();
      set_lane(0, 32'h0000_4000, 0, 0, 5, 32'h0);
      set_lane(1, 32'h0000_4004, 0, 0, 2, 32'h0);
      run_cycle("eret_hold");
    end
    clr_lanes(); ack = 1; run_cycle("eret_ack");

    // delay slot at address 0 wraps; then async reset while waiting for ack
    clr_lanes();
    set_lane(0, 32'h0000_0000, 1, 0, 6, 32'h0);
    run_cycle("wrap");
    clr_lanes(); run_cycle("wrap_wait");
    async_reset("rst_wait");

`ifdef EXC_TLB_EN
    clr_lanes(); exl = 0;
    set_lane(0, 32'h0000_5000, 0, 0, 10, 32'h0);
    run_cycle("refill_exl0");
    clr_lanes(); ack = 1; run_cycle("refill_exl0_ack");
    clr_lanes(); exl = 1;
    set_lane(0, 32'h0000_5000, 0, 0, 10, 32'h0);
    run_cycle("refill_exl1");
    clr_lanes(); ack = 1; run_cycle("refill_exl1_ack");
`endif

    for (int n = 0; n < 3000; n++) begin
      randomize_inputs();
      if (m_flush && $urandom_range(0, 40) == 0) async_reset("rnd_rst");
      else run_cycle("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
